// File: rtl/ace_rd_arbiter_pkg.sv
// Shared types and ACE encodings for the cache-refill read arbiter.
// Also holds the ARSNOOP codes that the refill requesters drive.
package ace_rd_arbiter_pkg;

  localparam int ARUSER_WIDTH = 1;

  localparam logic [3:0] ARCACHE_LINE_READ  = 4'b0011;
  localparam logic [1:0] ARDOMAIN_INNER     = 2'b01;
  localparam logic [1:0] ARBURST_INCR       = 2'b01;
  localparam logic [3:0] ARSNOOP_READSHARED = 4'b0001;
  localparam logic [3:0] ARSNOOP_READUNIQUE = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_ACK  = 2'd3
  } ace_rd_state_e;

  // Width-independent part of the AR payload captured at grant time.
  typedef struct packed {
    logic [3:0] snoop;
    logic       owner;
  } ar_ctrl_t;

endpackage

// File: rtl/ace_rd_arbiter_rr.sv
// Two-way round-robin grant with its own priority pointer.
// Reusable by the write and snoop paths.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
    gnt_o     = 2'b00;
    if (|req_i) gnt_o[gnt_idx_o] = 1'b1;
    // After a grant the port that lost gets priority next time.
    ptr_d = ptr_q;
    if (advance_i && (|req_i)) ptr_d = ~gnt_idx_o;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ace_rd_arbiter.sv
// Shares the single ACE read path between I-cache (port 0) and D-cache (port 1)
// refills: one line read at a time, round-robin grant, RACK after the last beat.
module ace_rd_arbiter
  import ace_rd_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4,
  parameter int LEN        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]              req_snoop,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [3:0]              rsp_resp,
  output logic                    rsp_last,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [3:0]              arsnoop,
  output logic [1:0]              ardomain,
  output logic [1:0]              arbar,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arlock,
  output logic [3:0]              arqos,
  output logic [3:0]              arregion,
  output logic [ARUSER_WIDTH-1:0] aruser,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [3:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    rack,
  output logic                    id_err
);

  localparam logic [7:0] ARLEN  = 8'(LEN);
  localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

  ace_rd_state_e          state_q, state_d;
  ar_ctrl_t               ctrl_q, ctrl_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   id_err_q, id_err_d;

  logic [1:0]             gnt;
  logic                   gnt_idx;
  logic                   in_idle, in_ar, in_r;
  logic                   r_hs;
  logic [ID_WIDTH-1:0]    arid_int;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_ar    = (state_q == ST_AR);
  assign in_r     = (state_q == ST_R);
  assign arid_int = ID_WIDTH'(ctrl_q.owner);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid),
    .advance_i (in_idle),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Requests are only seen in IDLE, so nothing is accepted while busy.
  assign req_ready = (in_idle && !rst) ? gnt : 2'b00;

  assign rready = in_r && rsp_ready[ctrl_q.owner];
  assign r_hs   = rvalid && rready;

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    addr_d   = addr_q;
    id_err_d = id_err_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          state_d      = ST_AR;
          ctrl_d.owner = gnt_idx;
          ctrl_d.snoop = gnt_idx ? req_snoop[7:4] : req_snoop[3:0];
          addr_d       = gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                 : req_addr[ADDR_WIDTH-1:0];
        end
      end
      ST_AR: begin
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        if (r_hs) begin
          if (rid != arid_int) id_err_d = 1'b1;
          if (rlast) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      id_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_err_q <= id_err_d;
    end
  end

  // Payload registers need no reset: every output using them is gated by state.
  always_ff @(posedge clk) begin
    ctrl_q <= ctrl_d;
    addr_q <= addr_d;
  end

  assign arvalid  = in_ar;
  assign arid     = in_ar ? arid_int           : '0;
  assign araddr   = in_ar ? addr_q             : '0;
  assign arlen    = in_ar ? ARLEN              : '0;
  assign arsize   = in_ar ? ARSIZE             : '0;
  assign arburst  = in_ar ? ARBURST_INCR       : '0;
  assign arsnoop  = in_ar ? ctrl_q.snoop       : '0;
  assign ardomain = in_ar ? ARDOMAIN_INNER     : '0;
  assign arcache  = in_ar ? ARCACHE_LINE_READ  : '0;
  assign arbar    = '0;
  assign arprot   = '0;
  assign arlock   = 1'b0;
  assign arqos    = '0;
  assign arregion = '0;
  assign aruser   = '0;

  // R beats pass straight through to the owner; the other port never sees them.
  assign rsp_valid = (in_r && rvalid) ? (ctrl_q.owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = in_r ? rdata : '0;
  assign rsp_resp  = in_r ? rresp : '0;
  assign rsp_last  = in_r ? rlast : 1'b0;

  assign rack   = (state_q == ST_ACK);
  assign id_err = id_err_q;

endmodule
